// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/result-memory block: operation encodings
// and the control FSM state type.
package alu_pkg;

    // Two-bit operation code presented on the op port.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // Control FSM: IDLE accepts, DIV waits on the iterative divider,
    // DONE is the single result-strobe cycle.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock.
// The first step is taken on the start edge straight from the inputs, so
// after WIDTH edges (start edge included) the result is final and done
// pulses for one cycle.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r, done_r;

    logic [WIDTH-1:0] src_rem_s, src_quo_s, src_dvs_s;
    logic [WIDTH:0]   shifted_s, diff_s;
    logic [WIDTH-1:0] new_rem_s, new_quo_s;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        src_rem_s = rem_r;
        src_quo_s = quo_r;
        src_dvs_s = dvs_r;
        if (start) begin
            src_rem_s = '0;
            src_quo_s = dividend;
            src_dvs_s = divisor;
        end else begin
            src_rem_s = rem_r;
            src_quo_s = quo_r;
            src_dvs_s = dvs_r;
        end
        shifted_s = {src_rem_s, src_quo_s[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, src_dvs_s};
        if (diff_s[WIDTH] == 1'b0) begin
            new_rem_s = diff_s[WIDTH-1:0];
        end else begin
            new_rem_s = shifted_s[WIDTH-1:0];
        end
        new_quo_s = {src_quo_s[WIDTH-2:0], ~diff_s[WIDTH]};
    end

    // Iteration state: load-and-step on start, then step until the count runs out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= new_rem_s;
            quo_r  <= new_quo_s;
            dvs_r  <= divisor;
            cnt_r  <= CW'(WIDTH - 1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= new_rem_s;
            quo_r <= new_quo_s;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/param_alu_regfile.sv
// Four-function unsigned ALU with a small result memory. Add/sub/mul and
// divide-by-zero finish in one cycle; real divides go through seq_divider.
// Results may be stored into mem at the captured address on the strobe cycle.
module param_alu_regfile
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] y,
    output logic               c,
    input  logic [AW-1:0]      rd_addr,
    output logic [2*WIDTH-1:0] rd_data
);

    state_e             state_r, state_nx_s;
    logic               in_ready_r, out_valid_r, c_r, we_r;
    logic [2*WIDTH-1:0] y_r;
    logic [AW-1:0]      addr_r;
    logic [2*WIDTH-1:0] mem_r [DEPTH];

    logic               accept_s, div_start_s, div_done_s;
    logic [WIDTH:0]     sum_s, dif_s;
    logic [2*WIDTH-1:0] prod_s, res_y_s;
    logic               res_c_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign accept_s    = in_valid && in_ready_r;
    assign div_start_s = accept_s && (op == OP_DIV) && (b != '0);
    assign sum_s       = {1'b0, a} + {1'b0, b};
    assign dif_s       = {1'b0, a} - {1'b0, b};
    assign prod_s      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done_s),
        .quotient  (quo_s),
        .remainder (rem_s)
    );

    // Single-cycle results; the OP_DIV arm only matters for a zero divisor.
    always_comb begin
        res_y_s = '0;
        res_c_s = 1'b0;
        case (op)
            OP_ADD: begin
                res_y_s = {{WIDTH{1'b0}}, sum_s[WIDTH-1:0]};
                res_c_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                res_y_s = {{WIDTH{1'b0}}, dif_s[WIDTH-1:0]};
                res_c_s = dif_s[WIDTH];
            end
            OP_MUL: begin
                res_y_s = prod_s;
                res_c_s = 1'b0;
            end
            OP_DIV: begin
                res_y_s = '0;
                res_c_s = 1'b1;
            end
            default: begin
                res_y_s = '0;
                res_c_s = 1'b0;
            end
        endcase
    end

    // Next-state logic for the IDLE/DIV/DONE control FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_start_s) begin
                    state_nx_s = DIV;
                end else if (accept_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DIV;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register plus registered handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Command capture and result registers; y/c hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r    <= '0;
            c_r    <= 1'b0;
            we_r   <= 1'b0;
            addr_r <= '0;
        end else begin
            if (accept_s) begin
                we_r   <= we;
                addr_r <= addr;
            end
            if (accept_s && !div_start_s) begin
                y_r <= res_y_s;
                c_r <= res_c_s;
            end else if ((state_r == DIV) && div_done_s) begin
                y_r <= {rem_s, quo_s};
                c_r <= 1'b0;
            end
        end
    end

    // Result memory: cleared by reset, written at the end of the strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if ((state_r == DONE) && we_r) begin
            mem_r[addr_r] <= y_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign c         = c_r;
    assign rd_data   = mem_r[rd_addr];

endmodule

// File: doc/param_alu_regfile.md
PARAM_ALU_REGFILE -- requirements
Module: param_alu_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have parameter DEPTH, default 8, meaning result-memory entries (power of two, at least 2).
REQ-003 SHALL have localparam AW = clog2(DEPTH), meaning address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning the command is presented.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a command this cycle.
REQ-008 SHALL have port a, input, WIDTH, meaning operand A (unsigned).
REQ-009 SHALL have port b, input, WIDTH, meaning operand B (unsigned).
REQ-010 SHALL have port op, input, 2, meaning 00 add, 01 sub, 10 mul, 11 div.
REQ-011 SHALL have port we, input, 1, meaning store the result on completion.
REQ-012 SHALL have port addr, input, AW, meaning the memory write address.
REQ-013 SHALL have port out_valid, output, 1, meaning a one-cycle result strobe.
REQ-014 SHALL have port y, output, 2*WIDTH, meaning the result.
REQ-015 SHALL have port c, output, 1, meaning carry, borrow or divide-error flag.
REQ-016 SHALL have port rd_addr, input, AW, meaning the memory read address.
REQ-017 SHALL have port rd_data, output, 2*WIDTH, meaning the asynchronous read of mem[rd_addr].

Function
REQ-018 Command SHALL be accepted when in_valid && in_ready; a, b, op, we and addr are captured at acceptance.
REQ-019 FSM SHALL have states IDLE, DIV and DONE; in_ready = 1 only in IDLE.
REQ-020 Add, sub, mul and divide-by-zero: IDLE -> DONE; out_valid asserts on the cycle after acceptance (latency 1).
REQ-021 Div with b != 0: IDLE -> DIV; restoring division, one quotient bit per cycle for WIDTH cycles; DIV -> DONE; out_valid asserts WIDTH+1 cycles after acceptance.
REQ-022 DONE -> IDLE unconditionally; there is no output backpressure.
REQ-023 Add: y = zero-extended (a+b) mod 2^WIDTH; c = carry-out bit WIDTH.
REQ-024 Sub: y = zero-extended (a-b) mod 2^WIDTH; c = 1 iff a < b.
REQ-025 Mul: y = full 2*WIDTH product; c = 0.
REQ-026 Div: y[WIDTH-1:0] = quotient, y[2*WIDTH-1:WIDTH] = remainder, c = 0.
REQ-027 Div by zero: y = 0 and c = 1.
REQ-028 y and c SHALL hold their last values between strobes.
REQ-029 On the out_valid cycle with captured we = 1, mem[captured addr] SHALL be written with y.
REQ-030 rd_data in the same cycle as a write to rd_addr returns the old contents; the new value is visible the next cycle.
REQ-031 in_valid while in_ready = 0 SHALL be ignored; no queuing.

Reset
REQ-032 While rst = 1: FSM -> IDLE; out_valid = 0; y = 0; c = 0; all DEPTH memory entries = 0; in_ready = 1 from the first cycle after rst deasserts.
REQ-033 Reset during DIV or DONE SHALL abort the operation: no out_valid and no memory write.
REQ-034 rst SHALL take priority over acceptance and write in the same cycle.

Structure
REQ-035 Op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state enum SHALL reside in shared package alu_pkg.
REQ-036 The iterative divider SHALL be sub-module seq_divider (start, dividend, divisor -> done, quotient, remainder); all other logic SHALL be inline.

Verification
Directed scenarios, WIDTH=8, DEPTH=8:
REQ-037 Add 200+100 -> one cycle later out_valid=1, y=0x002C, c=1.
REQ-038 Sub 5-9 -> y=0x00FC, c=1; mul 255*255 -> y=0xFE01, c=0.
REQ-039 Div 200/7, we=1, addr=3 -> in_ready low for 9 cycles; out_valid 9 cycles after acceptance with y=0x041C, c=0; next cycle rd_addr=3 gives rd_data=0x041C.
REQ-040 Div 17/0 -> one cycle later y=0, c=1; no DIV state entered.
REQ-041 Accept div 250/3 with we=1, addr=5, then assert rst at cycle 4 -> no out_valid; rd_data at addr 5 = 0; in_ready=1 after reset.
REQ-042 in_valid held during DIV with a different command -> ignored; only the original result is strobed, and the held command is accepted when IDLE is re-entered.
